seq_and_or_checker: RTL

//  Receive-side checker for the registered AND-OR datapath. Samples the a..g

---
 rtl/seq_and_or_pkg.sv | 23 ++
 rtl/seq_and_or_dly.sv | 46 ++++
 rtl/seq_and_or_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_and_or_pkg.sv
// Shared definitions for the AND-OR datapath checker.
//   state_e       : checker FSM encoding (visible on the state port)
//   FILL_W        : width of the pipe-fill counter (covers LAT up to 8)
//   golden_and_or : reference function n = (a&b&c&d) | (e&f&g)
package seq_and_or_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int FILL_W = 4;

  function automatic logic golden_and_or(input logic a, input logic b,
                                         input logic c, input logic d,
                                         input logic e, input logic f,
                                         input logic g);
    return (a & b & c & d) | (e & f & g);
  endfunction

endpackage

// File: rtl/seq_and_or_dly.sv
// LAT-deep {valid, expected} delay line.
//   clk, rst  : clock, async active-high reset
//   flush_i   : synchronous clear of all valid bits
//   hold_i    : freeze the line (no shift)
//   vld_i     : sample valid entering stage 0
//   exp_i     : expected result entering stage 0
//   vld_o     : tail (stage LAT-1) valid
//   exp_o     : tail expected result
module seq_and_or_dly #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic hold_i,
  input  logic vld_i,
  input  logic exp_i,
  output logic vld_o,
  output logic exp_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] exp_q;

  // Shifts every cycle, bubbles included, so a sample always reaches the
  // tail exactly LAT edges after it entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      exp_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else if (!hold_i) begin
      vld_q[0] <= vld_i;
      exp_q[0] <= exp_i;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        exp_q[k] <= exp_q[k-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign exp_o = exp_q[LAT-1];

endmodule

// File: rtl/seq_and_or_checker.sv
// Receive-side checker for the registered AND-OR datapath.
// Rebuilds n_exp = (a&b&c&d)|(e&f&g) through a LAT-deep delay line and
// compares it with the DUT output n.
//   clk, rst        : clock, async active-high reset
//   clear           : synchronous flush of pipe, counters, flags, FSM
//   en              : a..g valid this cycle
//   a..g            : stimulus presented to the DUT
//   n               : DUT output
//   mismatch        : one-cycle pulse after a failed compare
//   err_sticky      : any mismatch since rst/clear
//   chk_cnt         : samples compared (saturating)
//   err_cnt         : samples failed (saturating)
//   first_err_idx   : chk_cnt value of the first failing sample
//   state           : 0 IDLE, 1 FILL, 2 CHECK, 3 HALT
module seq_and_or_checker
  import seq_and_or_pkg::*;
#(
  parameter int LAT         = 1,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  input  logic             n,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  chk_q, chk_d, err_q, err_d, first_q, first_d;
  logic              mism_q, mism_d, sticky_q, sticky_d;
  logic              tail_vld, tail_exp, cmp, bad;

  seq_and_or_dly #(.LAT(LAT)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .flush_i(clear),
    .hold_i (state_q == ST_HALT),
    .vld_i  (en),
    .exp_i  (golden_and_or(a, b, c, d, e, f, g)),
    .vld_o  (tail_vld),
    .exp_o  (tail_exp)
  );

  // The first sample reaches the tail on the last FILL edge, so compares
  // are enabled in FILL as well as CHECK. The pipe is always empty in IDLE.
  assign cmp = tail_vld && (state_q == ST_FILL || state_q == ST_CHECK);
  assign bad = cmp && (n != tail_exp);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    chk_d    = chk_q;
    err_d    = err_q;
    first_d  = first_q;
    sticky_d = sticky_q;
    mism_d   = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      fill_d   = '0;
      chk_d    = '0;
      err_d    = '0;
      first_d  = '0;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (en) begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
        ST_FILL: begin
          if (fill_q == FILL_W'(LAT - 1)) state_d = ST_CHECK;
          else                            fill_d  = fill_q + FILL_W'(1);
        end
        default: ;
      endcase
      if (cmp) begin
        if (chk_q != CNT_MAX) chk_d = chk_q + CNT_W'(1);
        if (bad) begin
          mism_d   = 1'b1;
          sticky_d = 1'b1;
          if (err_q == '0)      first_d = chk_q;
          if (err_q != CNT_MAX) err_d   = err_q + CNT_W'(1);
          if (STOP_ON_ERR)      state_d = ST_HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      first_q  <= '0;
      mism_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      first_q  <= first_d;
      mism_q   <= mism_d;
      sticky_q <= sticky_d;
    end
  end

  assign mismatch      = mism_q;
  assign err_sticky    = sticky_q;
  assign chk_cnt       = chk_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;
  assign state         = state_q;

endmodule
